conv_window_ctrl: RTL and testbench
===================================

CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 Parameter BIT_DEPTH, default 8, pixel width; sets the width of the line-buffer datapath being sequenced.
REQ-002 Parameter COLS, default 28, image width in pixels; SHALL be >= 3.
REQ-003 Parameter ROWS, default 28, image height in pixels; SHALL be >= 3.
REQ-004 Parameter ADDR_W, default $clog2(ROWS*COLS), pixel-memory address width.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 start  in  1  one-cycle request to process one full image.
REQ-008 busy  out  1  high from the cycle after an accepted start until done.
REQ-009 done  out  1  one-cycle pulse after the last window completes.
REQ-010 mem_rd_en  out  1  synchronous pixel-memory read strobe; data returns the next cycle.
REQ-011 mem_addr_r1/r2/r3  out  ADDR_W each  row addresses for the top, middle and bottom window rows.
REQ-012 lb_wr_en  out  1  line-buffer write strobe; routes memory data into column 0 of all three rows.
REQ-013 lb_shift  out  1  line-buffer shift strobe.
REQ-014 win_valid  out  1  a 3x3 window is present in the line buffer.
REQ-015 win_ready  in  1  downstream accepts the window.
REQ-016 win_row  out  $clog2(ROWS)  top row index of the current window.
REQ-017 win_col  out  $clog2(COLS)  rightmost column index of the current window.

Function
REQ-018 FSM states: IDLE, READ, WRITE, WIN, SHIFT, NEXT_ROW, DONE.
REQ-019 IDLE to READ on start; col_cnt=0 and row_cnt=0 are loaded at the same time; start is ignored in every other state.
REQ-020 READ lasts 1 cycle with mem_rd_en=1 and mem_addr_rk=(row_cnt+k-1)*COLS+col_cnt for k=1..3; it then moves to WRITE.
REQ-021 WRITE lasts 1 cycle with lb_wr_en=1; it moves to WIN if col_cnt>=2, otherwise to SHIFT.
REQ-022 In WIN, win_valid=1, win_row=row_cnt and win_col=col_cnt; the state holds while win_ready=0 and moves to SHIFT in the cycle win_ready=1, so the minimum stay is 1 cycle.
REQ-023 SHIFT lasts 1 cycle with lb_shift=1.
REQ-024 From SHIFT the next state is decided as follows:
- col_cnt<COLS-1: col_cnt increments and the FSM goes to READ.
- col_cnt=COLS-1 and row_cnt<ROWS-3: NEXT_ROW.
- otherwise: DONE.
REQ-025 NEXT_ROW lasts 1 cycle; row_cnt increments, col_cnt clears, and the FSM goes to READ.
REQ-026 DONE lasts 1 cycle with done=1 and busy=0, then returns to IDLE.
REQ-027 lb_wr_en and lb_shift SHALL never be high in the same cycle.
REQ-028 busy=1 in READ, WRITE, WIN, SHIFT and NEXT_ROW, and 0 otherwise.
REQ-029 Outputs SHALL be registered or decoded from state only, with no combinational path from win_ready to any output.
REQ-030 Addresses SHALL be generated from a running row base (+COLS per band) with no multiplier.
REQ-031 With win_ready held high, one band takes 3*COLS+(COLS-2) cycles.
REQ-032 win_row and win_col SHALL hold their values while win_valid=0.

Reset
REQ-033 While rst_n=0, regardless of clk:
- state=IDLE;
- all counters, addresses, win_row and win_col = 0;
- busy, done, mem_rd_en, lb_wr_en, lb_shift and win_valid = 0.
REQ-034 Reset asserted mid-image SHALL abort the image with no done pulse; after release the block waits in IDLE for a new start.

Structure
REQ-035 State encoding and default parameter constants SHALL live in the shared package npu_pkg.
REQ-036 Address generation SHALL be a sub-module lb_addr_gen (row base, column counter, three address outputs).
REQ-037 The controller SHALL contain no pixel storage; it drives the existing line-buffer module.

Verification
REQ-038 COLS=4, ROWS=3, win_ready=1, start pulse → busy for 14 cycles; windows at (0,2) and (0,3); done pulses in the 15th cycle.
REQ-039 COLS=4, ROWS=4 → windows (0,2), (0,3), (1,2), (1,3); one NEXT_ROW cycle between bands; mem_addr_r1 in band 1 runs 4..7 and mem_addr_r3 runs 12..15.
REQ-040 win_ready held low for 5 cycles in the first WIN → win_valid high for 6 cycles; no lb_shift until the handshake; total time grows by exactly 5 cycles.
REQ-041 Start pulsed while busy → ignored; exactly one done pulse per accepted start.
REQ-042 rst_n asserted in a WIN state → all outputs 0 immediately and no done pulse; a later start runs a complete image correctly.
REQ-043 Assertion over every run: lb_wr_en and lb_shift are never high together, and every lb_wr_en is preceded by mem_rd_en in the cycle before.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU definitions: default image geometry and the window-controller state encoding.
package npu_pkg;

   localparam int unsigned DEF_BIT_DEPTH = 8;
   localparam int unsigned DEF_COLS      = 28;
   localparam int unsigned DEF_ROWS      = 28;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_WIN,
      ST_SHIFT,
      ST_NEXT_ROW,
      ST_DONE
   } ctrl_state_t;

endpackage

// File: rtl/lb_addr_gen.sv
// Row-base / column-counter address generator for the three window rows.
// Addresses are registered and track the values for the next READ; no multiplier.
module lb_addr_gen #(
   parameter int unsigned COLS   = 28,
   parameter int unsigned ADDR_W = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       col_inc,
   input  logic                       row_inc,
   output logic [$clog2(COLS)-1:0]    col_cnt,
   output logic [ADDR_W-1:0]          addr_r1,
   output logic [ADDR_W-1:0]          addr_r2,
   output logic [ADDR_W-1:0]          addr_r3
);

   localparam int unsigned CW = $clog2(COLS);
   localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] COLS2_A = ADDR_W'(2 * COLS);

   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [CW-1:0]     col_q, col_d;
   logic [ADDR_W-1:0] addr_r1_q, addr_r1_d;
   logic [ADDR_W-1:0] addr_r2_q, addr_r2_d;
   logic [ADDR_W-1:0] addr_r3_q, addr_r3_d;

   always_comb begin
      row_base_d = row_base_q;
      col_d      = col_q;
      addr_r1_d  = addr_r1_q;
      addr_r2_d  = addr_r2_q;
      addr_r3_d  = addr_r3_q;
      if (clr) begin
         row_base_d = '0;
         col_d      = '0;
      end else if (row_inc) begin
         row_base_d = row_base_q + COLS_A;
         col_d      = '0;
      end else if (col_inc) begin
         col_d      = col_q + CW'(1);
      end
      // Addresses are refreshed on every counter update so they are ready in the following READ.
      if (clr || row_inc || col_inc) begin
         addr_r1_d = row_base_d + ADDR_W'(col_d);
         addr_r2_d = addr_r1_d + COLS_A;
         addr_r3_d = addr_r1_d + COLS2_A;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_base_q <= '0;
         col_q      <= '0;
         addr_r1_q  <= '0;
         addr_r2_q  <= '0;
         addr_r3_q  <= '0;
      end else begin
         row_base_q <= row_base_d;
         col_q      <= col_d;
         addr_r1_q  <= addr_r1_d;
         addr_r2_q  <= addr_r2_d;
         addr_r3_q  <= addr_r3_d;
      end
   end

   assign col_cnt = col_q;
   assign addr_r1 = addr_r1_q;
   assign addr_r2 = addr_r2_q;
   assign addr_r3 = addr_r3_q;

endmodule

// File: rtl/conv_window_ctrl.sv
// 3x3 convolution window sequencer: reads pixel columns, fills and shifts the line buffer,
// and presents each complete window to a ready/valid consumer.
module conv_window_ctrl
   import npu_pkg::*;
#(
   parameter int unsigned BIT_DEPTH = DEF_BIT_DEPTH,
   parameter int unsigned COLS      = DEF_COLS,
   parameter int unsigned ROWS      = DEF_ROWS,
   parameter int unsigned ADDR_W    = $clog2(ROWS * COLS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       mem_rd_en,
   output logic [ADDR_W-1:0]          mem_addr_r1,
   output logic [ADDR_W-1:0]          mem_addr_r2,
   output logic [ADDR_W-1:0]          mem_addr_r3,
   output logic                       lb_wr_en,
   output logic                       lb_shift,
   output logic                       win_valid,
   input  logic                       win_ready,
   output logic [$clog2(ROWS)-1:0]    win_row,
   output logic [$clog2(COLS)-1:0]    win_col
);

   localparam int unsigned RW = $clog2(ROWS);
   localparam int unsigned CW = $clog2(COLS);

   if (BIT_DEPTH == 0 || COLS < 3 || ROWS < 3) begin : g_bad_params
      $error("conv_window_ctrl: BIT_DEPTH must be > 0 and COLS/ROWS must be >= 3");
   end

   ctrl_state_t   state_q, state_d;
   logic [RW-1:0] row_cnt_q, row_cnt_d;
   logic [RW-1:0] win_row_q, win_row_d;
   logic [CW-1:0] win_col_q, win_col_d;
   logic [CW-1:0] col_cnt;
   logic          addr_clr, col_inc, row_inc;

   lb_addr_gen #(
      .COLS   (COLS),
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (addr_clr),
      .col_inc (col_inc),
      .row_inc (row_inc),
      .col_cnt (col_cnt),
      .addr_r1 (mem_addr_r1),
      .addr_r2 (mem_addr_r2),
      .addr_r3 (mem_addr_r3)
   );

   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      win_row_d = win_row_q;
      win_col_d = win_col_q;
      addr_clr  = 1'b0;
      col_inc   = 1'b0;
      row_inc   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_READ;
               row_cnt_d = '0;
               addr_clr  = 1'b1;
            end
         end
         ST_READ:  state_d = ST_WRITE;
         ST_WRITE: begin
            // Window coordinates are captured on entry so they stay stable outside WIN.
            if (col_cnt >= CW'(2)) begin
               state_d   = ST_WIN;
               win_row_d = row_cnt_q;
               win_col_d = col_cnt;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_WIN: begin
            if (win_ready) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (col_cnt < CW'(COLS - 1)) begin
               col_inc = 1'b1;
               state_d = ST_READ;
            end else if (row_cnt_q < RW'(ROWS - 3)) begin
               state_d = ST_NEXT_ROW;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_NEXT_ROW: begin
            row_inc   = 1'b1;
            row_cnt_d = row_cnt_q + RW'(1);
            state_d   = ST_READ;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         row_cnt_q <= '0;
         win_row_q <= '0;
         win_col_q <= '0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         win_row_q <= win_row_d;
         win_col_q <= win_col_d;
      end
   end

   assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done      = (state_q == ST_DONE);
   assign mem_rd_en = (state_q == ST_READ);
   assign lb_wr_en  = (state_q == ST_WRITE);
   assign lb_shift  = (state_q == ST_SHIFT);
   assign win_valid = (state_q == ST_WIN);
   assign win_row   = win_row_q;
   assign win_col   = win_col_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Randomized self-checking bench for conv_window_ctrl against a scan-order reference model.
module tb_conv_window_ctrl;

   localparam int COLS   = 4;
   localparam int ROWS   = 4;
   localparam int ADDR_W = $clog2(ROWS * COLS);
   localparam int RW     = $clog2(ROWS);
   localparam int CW     = $clog2(COLS);
   localparam int BANDS  = ROWS - 2;
   localparam int NWIN   = BANDS * (COLS - 2);

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              busy;
   logic              done;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr_r1;
   logic [ADDR_W-1:0] mem_addr_r2;
   logic [ADDR_W-1:0] mem_addr_r3;
   logic              lb_wr_en;
   logic              lb_shift;
   logic              win_valid;
   logic              win_ready;
   logic [RW-1:0]     win_row;
   logic [CW-1:0]     win_col;

   conv_window_ctrl #(
      .BIT_DEPTH (8),
      .COLS      (COLS),
      .ROWS      (ROWS),
      .ADDR_W    (ADDR_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .mem_rd_en   (mem_rd_en),
      .mem_addr_r1 (mem_addr_r1),
      .mem_addr_r2 (mem_addr_r2),
      .mem_addr_r3 (mem_addr_r3),
      .lb_wr_en    (lb_wr_en),
      .lb_shift    (lb_shift),
      .win_valid   (win_valid),
      .win_ready   (win_ready),
      .win_row     (win_row),
      .win_col     (win_col)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int plan[$];
   logic [RW-1:0] last_row = '0;
   logic [CW-1:0] last_col = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctrl"}, 32'({busy, done, mem_rd_en, lb_wr_en, lb_shift, win_valid}), 32'd0);
      chk({tag, "_addr"}, 32'({mem_addr_r1, mem_addr_r2, mem_addr_r3}), 32'd0);
      chk({tag, "_win"},  32'({win_row, win_col}), 32'd0);
   endtask

   // Runs one image; plan[i] is the number of cycles window i is held off before acceptance.
   task automatic run_image(input bit poke, output int first_len);
      int   exp_rd[$];
      int   exp_win[$];
      int   tgt[$];
      int   busy_cnt = 0, done_cnt = 0, shift_cnt = 0, viol = 0, hold_err = 0;
      int   cycles = 0, stall_sum = 0, win_idx = 0, stall_cnt = 0, cur = 0;
      bit   prev_rd = 1'b0, prev_busy = 1'b0, finished = 1'b0;
      first_len = 0;
      for (int r = 0; r < BANDS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            exp_rd.push_back((r * COLS + c) | (((r + 1) * COLS + c) << 8) | (((r + 2) * COLS + c) << 16));
            if (c >= 2) exp_win.push_back(r * 16 + c);
         end
      end
      for (int i = 0; i < NWIN; i++) begin
         int t;
         t = (i < plan.size()) ? plan[i] : 0;
         tgt.push_back(t);
         stall_sum += t;
      end
      cur = tgt.pop_front();

      @(negedge clk);
      start = 1'b1;
      while (!finished) begin
         @(negedge clk);
         start = 1'b0;
         cycles++;
         if (cycles == 1) chk("busy_after_start", 32'(busy), 32'd1);
         if (busy) busy_cnt++;
         if (lb_shift) shift_cnt++;
         if (lb_wr_en && lb_shift) viol++;
         if (lb_wr_en && !prev_rd) viol++;
         if (mem_rd_en) begin
            if (exp_rd.size() == 0) viol++;
            else chk("rd_addr", 32'(mem_addr_r1) | (32'(mem_addr_r2) << 8) | (32'(mem_addr_r3) << 16),
                     32'(exp_rd.pop_front()));
         end
         if (win_valid) begin
            last_row = win_row;
            last_col = win_col;
            if (win_idx == 0) first_len++;
            if (stall_cnt < cur) begin
               win_ready = 1'b0;
               stall_cnt++;
            end else begin
               win_ready = 1'b1;
               if (exp_win.size() == 0) viol++;
               else chk("win_pos", 32'(win_row) * 16 + 32'(win_col), 32'(exp_win.pop_front()));
               win_idx++;
               stall_cnt = 0;
               cur = (tgt.size() > 0) ? tgt.pop_front() : 0;
            end
         end else begin
            if (win_row !== last_row || win_col !== last_col) hold_err++;
            win_ready = 1'($urandom_range(0, 1));
         end
         if (done) begin
            done_cnt++;
            chk("done_after_busy", 32'({prev_busy, busy}), 32'd2);
            finished = 1'b1;
         end
         start = poke && busy && ($urandom_range(0, 3) == 0);
         prev_rd   = mem_rd_en;
         prev_busy = busy;
         if (cycles > 2000) begin
            chk("timeout", 32'd0, 32'd1);
            finished = 1'b1;
         end
      end
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) done_cnt++;
         if (busy) busy_cnt++;
      end
      chk("busy_cycles", 32'(busy_cnt), 32'(BANDS * (4 * COLS - 2) + (BANDS - 1) + stall_sum));
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("reads_left", 32'(exp_rd.size()), 32'd0);
      chk("wins_left", 32'(exp_win.size()), 32'd0);
      chk("shift_count", 32'(shift_cnt), 32'(BANDS * COLS));
      chk("strobe_rules", 32'(viol), 32'd0);
      chk("win_hold", 32'(hold_err), 32'd0);
   endtask

   task automatic reset_mid_win();
      int waited = 0;
      int seen_done = 0, seen_busy = 0;
      win_ready = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!win_valid && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      chk("reach_win", 32'(win_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_rst");
      repeat (4) begin
         @(negedge clk);
         win_ready = 1'($urandom_range(0, 1));
         if (done) seen_done++;
      end
      rst_n = 1'b1;
      last_row = '0;
      last_col = '0;
      repeat (5) begin
         @(negedge clk);
         if (done) seen_done++;
         if (busy) seen_busy++;
      end
      chk("rst_no_done", 32'(seen_done), 32'd0);
      chk("rst_idle_wait", 32'(seen_busy), 32'd0);
   endtask

   initial begin
      int len;
      rst_n     = 1'b0;
      start     = 1'b0;
      win_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      plan.delete();
      run_image(1'b0, len);
      chk("no_stall_first_len", 32'(len), 32'd1);

      plan.delete();
      plan.push_back(5);
      run_image(1'b0, len);
      chk("stall5_first_len", 32'(len), 32'd6);

      for (int n = 0; n < 4; n++) begin
         plan.delete();
         for (int i = 0; i < NWIN; i++) plan.push_back(int'($urandom_range(0, 3)));
         run_image(1'b1, len);
         chk("rand_first_len", 32'(len), 32'(plan[0] + 1));
      end

      reset_mid_win();
      plan.delete();
      for (int i = 0; i < NWIN; i++) plan.push_back(int'($urandom_range(0, 2)));
      run_image(1'b1, len);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
